division_sequencer: RTL and testbench
=====================================

DIVISION_SEQUENCER -- requirements
Module: division_sequencer

Interface
REQ-001 SHALL have parameters: WIDTH, default 4, operand width matching the attached Divider; DEPTH, default 4, request FIFO entries (power of two); TAG_WIDTH, default 2, request tag width.
REQ-002 SHALL have ports: clock  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: reset_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: request_valid  in  1 / request_ready  out  1  request handshake.
REQ-005 SHALL have ports: request_dividend, request_divisor  in  WIDTH  signed operands; request_tag  in  TAG_WIDTH.
REQ-006 SHALL have ports: response_valid  out  1 / response_ready  in  1  response handshake.
REQ-007 SHALL have ports: response_quotient, response_remainder  out  WIDTH; response_fault  out  1; response_tag  out  TAG_WIDTH.
REQ-008 SHALL have ports: divider_start  out  1; divider_dividend, divider_divisor  out  WIDTH; these drive the Divider.
REQ-009 SHALL have ports: divider_quotient, divider_remainder  in  WIDTH; divider_ready  in  1; these come from the Divider. The Divider fault output is not used.

Function
REQ-010 SHALL transfer a request on a rising edge where request_valid and request_ready are both high.
REQ-011 SHALL hold accepted requests in a DEPTH-entry FIFO; request_ready = not full.
REQ-012 SHALL NOT accept a request while the FIFO is full, even if a pop occurs in the same cycle.
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESPOND.
REQ-014 IDLE: if the FIFO is non-empty, SHALL pop the head into operand/tag registers. Next state is ISSUE, or RESPOND if the divisor is 0.
REQ-015 Divisor 0 SHALL bypass the Divider: response_quotient 0, response_remainder 0, response_fault 1, and no divider_start pulse.
REQ-016 ISSUE: SHALL assert divider_start, registered, for exactly one cycle, with divider_dividend/divider_divisor stable from ISSUE until leaving WAIT. Next state is WAIT.
REQ-017 WAIT: SHALL ignore divider_ready outside WAIT. In WAIT, divider_ready high SHALL capture divider_quotient/divider_remainder with fault 0, then go to RESPOND. The Divider's fast paths leave ready high in the first WAIT cycle; its iterative path lowers ready first.
REQ-018 WAIT SHALL run a watchdog counter of 2*WIDTH cycles. On expiry it SHALL go to RESPOND with quotient 0, remainder 0, fault 1.
REQ-019 RESPOND: SHALL hold response_valid high with all response fields stable until response_ready. On the handshake edge it SHALL go to IDLE.
REQ-020 SHALL keep at most one operation outstanding at the Divider; responses leave in request order.
REQ-021 Latency from request-accept edge e0 with an empty FIFO: ISSUE after e1, WAIT after e2, response_valid after e3 (fast path). For WIDTH=4 iterative operands, response_valid follows e7.
REQ-022 A request pushed during RESPOND SHALL be popped no earlier than the first IDLE cycle.

Reset
REQ-023 reset_n low at a clock edge SHALL clear the FIFO, set state IDLE, and clear the watchdog.
REQ-024 That same reset SHALL drive divider_start=0, response_valid=0, response_fault=0, and response data/tag=0.
REQ-025 request_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-026 Reset mid-operation SHALL abandon the in-flight operation and emit no response for it. Any stale divider_ready SHALL be ignored until a fresh ISSUE.

Structure
REQ-027 The shared package division_pkg SHALL hold the FSM state encoding (2 bits), the watchdog limit expression, and default parameter constants.
REQ-028 The FIFO SHALL be a separate sub-module request_fifo, parameterised on width and DEPTH, with push/pop/full/empty ports.
REQ-029 The Divider SHALL be instantiated outside this block; this block connects only to its ports.

Verification
REQ-030 Reset, then request 7/2 tag 1 -> response after e7: quotient 3, remainder 1, fault 0, tag 1.
REQ-031 Request -6/1 -> Divider fast path, response_valid after e3: quotient -6, remainder 0, fault 0.
REQ-032 Request 5/0 tag 2 -> no divider_start pulse; response quotient 0, remainder 0, fault 1, tag 2.
REQ-033 Push 5 requests back-to-back with response_ready low -> request_ready low after 4 accepts. Releasing response_ready yields responses in tag order, and fields stay stable while stalled.
REQ-034 Hold divider_ready low in WAIT -> fault response after 8 cycles (WIDTH=4). Then next request completes normally.
REQ-035 Assert reset_n low during WAIT -> no response; FIFO empty; next request completes with correct values.

Source files
------------

// File: rtl/division_pkg.sv
// Shared constants for the division sequencer: default sizes, FSM encoding,
// and the Divider watchdog limit.
package division_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_TAG_WIDTH = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    // Cycles spent in WAIT before a silent Divider is declared hung.
    function automatic int watchdog_limit(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/request_fifo.sv
// Show-ahead request FIFO: the head entry is visible on o_pop_data whenever
// o_empty is low. Push while full and pop while empty are ignored.
module request_fifo
    import division_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_WIDTH + DEF_TAG_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/division_sequencer.sv
// Queues signed division requests and feeds them one at a time to an external
// Divider, returning tagged results (or a fault) in request order.
module division_sequencer
    import division_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        request_valid,
    output logic                        request_ready,
    input  logic signed [WIDTH-1:0]     request_dividend,
    input  logic signed [WIDTH-1:0]     request_divisor,
    input  logic        [TAG_WIDTH-1:0] request_tag,
    output logic                        response_valid,
    input  logic                        response_ready,
    output logic signed [WIDTH-1:0]     response_quotient,
    output logic signed [WIDTH-1:0]     response_remainder,
    output logic                        response_fault,
    output logic        [TAG_WIDTH-1:0] response_tag,
    output logic                        divider_start,
    output logic signed [WIDTH-1:0]     divider_dividend,
    output logic signed [WIDTH-1:0]     divider_divisor,
    input  logic signed [WIDTH-1:0]     divider_quotient,
    input  logic signed [WIDTH-1:0]     divider_remainder,
    input  logic                        divider_ready
);

    localparam int ENTRY_W  = 2 * WIDTH + TAG_WIDTH;
    localparam int WD_LIMIT = watchdog_limit(WIDTH);
    localparam int WD_W     = $clog2(WD_LIMIT);

    logic [1:0]                  r_state;
    logic                        r_start;
    logic [WD_W-1:0]             r_wd_cnt;
    logic signed [WIDTH-1:0]     r_dividend;
    logic signed [WIDTH-1:0]     r_divisor;
    logic [TAG_WIDTH-1:0]        r_tag;
    logic signed [WIDTH-1:0]     r_quotient;
    logic signed [WIDTH-1:0]     r_remainder;
    logic                        r_fault;
    logic [TAG_WIDTH-1:0]        r_resp_tag;

    logic                        w_full;
    logic                        w_empty;
    logic                        w_push;
    logic                        w_pop;
    logic [ENTRY_W-1:0]          w_head;
    logic signed [WIDTH-1:0]     w_head_dividend;
    logic signed [WIDTH-1:0]     w_head_divisor;
    logic [TAG_WIDTH-1:0]        w_head_tag;

    // Ready depends on full alone, so a same-cycle pop never frees a slot early.
    assign request_ready = !w_full;
    assign w_push        = request_valid && !w_full;
    assign w_pop         = (r_state == ST_IDLE) && !w_empty;

    request_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_request_fifo (
        .clk         (clock),
        .rst_n       (reset_n),
        .i_push      (w_push),
        .i_push_data ({request_dividend, request_divisor, request_tag}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign w_head_dividend = w_head[ENTRY_W-1 -: WIDTH];
    assign w_head_divisor  = w_head[TAG_WIDTH +: WIDTH];
    assign w_head_tag      = w_head[TAG_WIDTH-1:0];

    assign divider_start      = r_start;
    assign divider_dividend   = r_dividend;
    assign divider_divisor    = r_divisor;
    assign response_valid     = (r_state == ST_RESPOND);
    assign response_quotient  = r_quotient;
    assign response_remainder = r_remainder;
    assign response_fault     = r_fault;
    assign response_tag       = r_resp_tag;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_start     <= 1'b0;
            r_wd_cnt    <= '0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_tag       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_fault     <= 1'b0;
            r_resp_tag  <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_dividend <= w_head_dividend;
                        r_divisor  <= w_head_divisor;
                        r_tag      <= w_head_tag;
                        // A zero divisor never reaches the Divider.
                        if (w_head_divisor == '0) begin
                            r_quotient  <= '0;
                            r_remainder <= '0;
                            r_fault     <= 1'b1;
                            r_resp_tag  <= w_head_tag;
                            r_state     <= ST_RESPOND;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_wd_cnt <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (divider_ready) begin
                        r_quotient  <= divider_quotient;
                        r_remainder <= divider_remainder;
                        r_fault     <= 1'b0;
                        r_resp_tag  <= r_tag;
                        r_state     <= ST_RESPOND;
                    end else if (r_wd_cnt == WD_W'(WD_LIMIT - 1)) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                        r_fault     <= 1'b1;
                        r_resp_tag  <= r_tag;
                        r_state     <= ST_RESPOND;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    end
                end
                ST_RESPOND: begin
                    if (response_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_division_sequencer.sv
// Bench for division_sequencer with a behavioural Divider model, a queue-based
// response scoreboard, directed vectors and randomized traffic.
module tb_division_sequencer;

    localparam int W  = 4;
    localparam int TW = 2;
    localparam int NRAND = 150;

    logic                 clock;
    logic                 reset_n;
    logic                 request_valid;
    logic                 request_ready;
    logic signed [W-1:0]  request_dividend;
    logic signed [W-1:0]  request_divisor;
    logic [TW-1:0]        request_tag;
    logic                 response_valid;
    logic                 response_ready;
    logic signed [W-1:0]  response_quotient;
    logic signed [W-1:0]  response_remainder;
    logic                 response_fault;
    logic [TW-1:0]        response_tag;
    logic                 divider_start;
    logic signed [W-1:0]  divider_dividend;
    logic signed [W-1:0]  divider_divisor;
    logic signed [W-1:0]  divider_quotient  = '0;
    logic signed [W-1:0]  divider_remainder = '0;
    logic                 divider_ready     = 1'b1;

    division_sequencer #(.WIDTH(W), .DEPTH(4), .TAG_WIDTH(TW)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .request_valid      (request_valid),
        .request_ready      (request_ready),
        .request_dividend   (request_dividend),
        .request_divisor    (request_divisor),
        .request_tag        (request_tag),
        .response_valid     (response_valid),
        .response_ready     (response_ready),
        .response_quotient  (response_quotient),
        .response_remainder (response_remainder),
        .response_fault     (response_fault),
        .response_tag       (response_tag),
        .divider_start      (divider_start),
        .divider_dividend   (divider_dividend),
        .divider_divisor    (divider_divisor),
        .divider_quotient   (divider_quotient),
        .divider_remainder  (divider_remainder),
        .divider_ready      (divider_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int start_cnt = 0;
    bit hang = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (divider_start) start_cnt <= start_cnt + 1;

    // Divider: divisor +/-1 answers at once; others go busy for W cycles and
    // read the operand ports again at completion. hang keeps ready low.
    int div_cnt  = 0;
    bit div_busy = 1'b0;
    always @(posedge clock) begin
        if (divider_start) begin
            if (hang) begin
                divider_ready <= 1'b0;
                div_busy      <= 1'b0;
            end else if (divider_divisor == 4'sd1 || divider_divisor == -4'sd1) begin
                divider_quotient  <= W'(int'(divider_dividend) / int'(divider_divisor));
                divider_remainder <= W'(int'(divider_dividend) % int'(divider_divisor));
                divider_ready     <= 1'b1;
                div_busy          <= 1'b0;
            end else begin
                divider_ready <= 1'b0;
                div_busy      <= 1'b1;
                div_cnt       <= W;
            end
        end else if (div_busy) begin
            if (div_cnt == 1) begin
                divider_quotient  <= W'(int'(divider_dividend) / int'(divider_divisor));
                divider_remainder <= W'(int'(divider_dividend) % int'(divider_divisor));
                divider_ready     <= 1'b1;
                div_busy          <= 1'b0;
            end else begin
                div_cnt <= div_cnt - 1;
            end
        end
    end

    typedef struct { int q; int r; int f; int tag; } exp_t;
    exp_t exp_q[$];

    function automatic exp_t model(input int a, input int b, input int tag, input bit hg);
        exp_t e;
        logic signed [W-1:0] qs;
        logic signed [W-1:0] rs;
        e.tag = tag;
        if (b == 0 || hg) begin
            e.q = 0; e.r = 0; e.f = 1;
        end else begin
            qs = W'(a / b);
            rs = W'(a % b);
            e.q = qs; e.r = rs; e.f = 0;
        end
        return e;
    endfunction

    // Scoreboard: queue expected results at each accept, compare at each
    // response handshake, and require fields to hold while stalled.
    bit prev_stall = 1'b0;
    int pq, pr, pf, pt;
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (request_valid && request_ready)
                exp_q.push_back(model(request_dividend, request_divisor, request_tag, hang));
            if (prev_stall) begin
                chk("valid_held", response_valid, 1);
                chk("stable_q", response_quotient, pq);
                chk("stable_r", response_remainder, pr);
                chk("stable_fault", response_fault, pf);
                chk("stable_tag", response_tag, pt);
            end
            if (response_valid && response_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_q", response_quotient, e.q);
                    chk("sb_r", response_remainder, e.r);
                    chk("sb_fault", response_fault, e.f);
                    chk("sb_tag", response_tag, e.tag);
                end
            end
            prev_stall = response_valid && !response_ready;
            pq = response_quotient; pr = response_remainder;
            pf = response_fault;    pt = response_tag;
        end
    end

    typedef struct { int a; int b; int tag; bit hang; int q; int r; int f; int lat; } vec_t;
    vec_t vecs[11];

    task automatic run_vec(input vec_t v);
        int e0, s0;
        bit found;
        hang = v.hang;
        response_ready = 1'b1;
        @(posedge clock); #1;
        request_dividend = W'(v.a);
        request_divisor  = W'(v.b);
        request_tag      = TW'(v.tag);
        request_valid    = 1'b1;
        s0 = start_cnt;
        @(negedge clock);
        chk("vec_req_ready", request_ready, 1);
        @(posedge clock); #1;
        request_valid = 1'b0;
        e0 = cyc;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (response_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("vec_resp_seen", found, 1);
        if (found) begin
            chk("vec_latency", cyc - e0, v.lat);
            chk("vec_q", response_quotient, v.q);
            chk("vec_r", response_remainder, v.r);
            chk("vec_fault", response_fault, v.f);
            chk("vec_tag", response_tag, v.tag);
            chk("vec_starts", start_cnt - s0, (v.b != 0) ? 1 : 0);
        end
        @(posedge clock);
        @(posedge clock);
        hang = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !response_valid) break;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "time limit");
    end

    initial begin
        int acc, seen, sent;
        bit rdy, found, a;

        vecs[0]  = '{ 7,  2, 1, 1'b0,  3,  1, 0,  7};
        vecs[1]  = '{-6,  1, 0, 1'b0, -6,  0, 0,  3};
        vecs[2]  = '{ 5,  0, 2, 1'b0,  0,  0, 1,  1};
        vecs[3]  = '{-7,  2, 3, 1'b0, -3, -1, 0,  7};
        vecs[4]  = '{ 7, -1, 1, 1'b0, -7,  0, 0,  3};
        vecs[5]  = '{-8, -1, 2, 1'b0, -8,  0, 0,  3};
        vecs[6]  = '{ 0,  0, 0, 1'b0,  0,  0, 1,  1};
        vecs[7]  = '{ 6, -4, 3, 1'b0, -1,  2, 0,  7};
        vecs[8]  = '{ 3,  2, 1, 1'b1,  0,  0, 1, 10};
        vecs[9]  = '{ 3,  2, 2, 1'b0,  1,  1, 0,  7};
        vecs[10] = '{ 5,  2, 2, 1'b0,  2,  1, 0,  7};

        reset_n = 1'b0;
        request_valid = 1'b0;
        request_dividend = '0;
        request_divisor = '0;
        request_tag = '0;
        response_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_resp_valid", response_valid, 0);
        chk("rst_start", divider_start, 0);
        chk("rst_fault", response_fault, 0);
        chk("rst_q", response_quotient, 0);
        chk("rst_r", response_remainder, 0);
        chk("rst_tag", response_tag, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_req_ready", request_ready, 1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Full FIFO behind a stalled response.
        response_ready = 1'b0;
        @(posedge clock); #1;
        request_dividend = 4'sd1; request_divisor = 4'sd1; request_tag = 2'd0;
        request_valid = 1'b1;
        @(posedge clock); #1;
        request_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (response_valid) begin found = 1'b1; break; end
        end
        chk("stall_resp_seen", found, 1);
        acc = 0;
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            request_dividend = W'(i + 2);
            request_divisor  = 4'sd1;
            request_tag      = TW'(i + 1);
            request_valid    = 1'b1;
            @(negedge clock);
            rdy = request_ready;
            if (!rdy) break;
            acc++;
        end
        chk("accepts_before_full", acc, 4);
        chk("ready_low_when_full", rdy, 0);
        @(posedge clock); #1;
        response_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("ready_low_during_pop", request_ready, 0);
        @(posedge clock);
        @(negedge clock);
        chk("ready_after_pop", request_ready, 1);
        @(posedge clock); #1;
        request_valid = 1'b0;
        wait_drain();

        // Reset in WAIT abandons the operation.
        @(posedge clock); #1;
        request_dividend = 4'sd7; request_divisor = 4'sd3; request_tag = 2'd1;
        request_valid = 1'b1;
        @(posedge clock); #1;
        request_valid = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (response_valid) seen++;
        end
        chk("no_resp_after_reset", seen, 0);
        chk("ready_after_mid_reset", request_ready, 1);
        run_vec(vecs[10]);

        // Randomized traffic with random response back-pressure.
        sent = 0;
        for (int c = 0; c < 8000 && sent < NRAND; c++) begin
            @(negedge clock);
            a = request_valid && request_ready;
            @(posedge clock); #1;
            if (a) begin
                sent++;
                request_valid = 1'b0;
            end
            if (!request_valid && sent < NRAND && $urandom_range(0, 2) != 0) begin
                request_dividend = W'($urandom_range(0, 15));
                request_divisor  = ($urandom_range(0, 7) == 0) ? 4'sd0 : W'($urandom_range(0, 15));
                request_tag      = TW'($urandom_range(0, 3));
                request_valid    = 1'b1;
            end
            response_ready = ($urandom_range(0, 3) != 0);
        end
        request_valid = 1'b0;
        response_ready = 1'b1;
        chk("rand_sent", sent, NRAND);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
